// File: rtl/aes_pkg.sv
// Shared AES constants, byte type and the GF(2^8) multiply helper used by the S-box core.
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam aes_byte_t  AES_AFFINE_C     = 8'h63;
    localparam aes_byte_t  AES_INV_AFFINE_C = 8'h05;
    localparam logic [8:0] AES_POLY         = 9'h11B;

    // Shift-and-add multiply, reducing by the AES polynomial whenever x^8 appears.
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t acc;
        aes_byte_t sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end else begin
                acc = acc;
            end
            if (sh[7]) begin
                sh = (sh << 1) ^ AES_POLY[7:0];
            end else begin
                sh = sh << 1;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox_core.sv
// Combinational AES S-box: GF inverse as x^254, with forward and (under AES_SBOX_INV_EN) inverse affine.
module aes_sbox_core
    import aes_pkg::*;
(
    input  logic [7:0] data_i,
    input  logic       inv_i,
    output logic [7:0] data_o
);

    // Addition chain 2,3,6,12,15,30,60,120,240 then 240+12+2 = 254; x^254 also maps 0 to 0.
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic aes_byte_t aff_fwd(input aes_byte_t a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ AES_AFFINE_C;
    endfunction

`ifdef AES_SBOX_INV_EN
    function automatic aes_byte_t aff_inv(input aes_byte_t a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ AES_INV_AFFINE_C;
    endfunction

    // Direction select between the two substitution orders.
    always_comb begin
        data_o = 8'h00;
        if (inv_i) begin
            data_o = gf_inv(aff_inv(data_i));
        end else begin
            data_o = aff_fwd(gf_inv(data_i));
        end
    end
`else
    logic unused_inv_s;
    assign unused_inv_s = inv_i;

    // Forward-only substitution.
    always_comb begin
        data_o = aff_fwd(gf_inv(data_i));
    end
`endif

endmodule

// File: rtl/aes_sbox_server.sv
// Shared S-box responder: key scheduler has absolute priority over the datapath, one-cycle latency.
// Optional inverse support is enabled with the AES_SBOX_INV_EN macro.
module aes_sbox_server
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sbox_access_i,
    input  logic [7:0] sbox_data_i,
    input  logic       sbox_decrypt_i,
    output logic [7:0] sbox_data_o,
    output logic       sbox_valid_o,
    input  logic       dp_access_i,
    input  logic [7:0] dp_data_i,
    input  logic       dp_decrypt_i,
    output logic       dp_grant_o,
    output logic [7:0] dp_data_o,
    output logic       dp_valid_o,
    input  logic       clear_i,
    output logic       collision_o,
    output logic       inv_err_o
);

    aes_byte_t sel_data_s;
    logic      sel_inv_s;
    aes_byte_t core_out_s;
    logic      dp_grant_s;
    logic      collision_set_s;
    logic      inv_err_set_s;

    aes_byte_t sbox_data_q, sbox_data_d;
    aes_byte_t dp_data_q,   dp_data_d;
    logic      sbox_valid_q, dp_valid_q;
    logic      collision_q, collision_d;
    logic      inv_err_q,   inv_err_d;

    assign dp_grant_s = dp_access_i & ~sbox_access_i;

    // Arbitration mux and next-state for the result registers and sticky flags.
    always_comb begin
        if (sbox_access_i) begin
            sel_data_s = sbox_data_i;
            sel_inv_s  = sbox_decrypt_i;
        end else begin
            sel_data_s = dp_data_i;
            sel_inv_s  = dp_decrypt_i;
        end

        collision_set_s = sbox_access_i & dp_access_i;
`ifdef AES_SBOX_INV_EN
        inv_err_set_s = 1'b0;
`else
        inv_err_set_s = (sbox_access_i & sbox_decrypt_i) | (dp_grant_s & dp_decrypt_i);
`endif

        if (sbox_access_i) begin
            sbox_data_d = core_out_s;
        end else begin
            sbox_data_d = sbox_data_q;
        end
        if (dp_grant_s) begin
            dp_data_d = core_out_s;
        end else begin
            dp_data_d = dp_data_q;
        end

        // Set dominates clear when both happen in one cycle.
        collision_d = collision_set_s | (collision_q & ~clear_i);
        inv_err_d   = inv_err_set_s   | (inv_err_q   & ~clear_i);
    end

    aes_sbox_core u_core (
        .data_i (sel_data_s),
        .inv_i  (sel_inv_s),
        .data_o (core_out_s)
    );

    // Result, valid and sticky-flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sbox_data_q  <= 8'h00;
            dp_data_q    <= 8'h00;
            sbox_valid_q <= 1'b0;
            dp_valid_q   <= 1'b0;
            collision_q  <= 1'b0;
            inv_err_q    <= 1'b0;
        end else begin
            sbox_data_q  <= sbox_data_d;
            dp_data_q    <= dp_data_d;
            sbox_valid_q <= sbox_access_i;
            dp_valid_q   <= dp_grant_s;
            collision_q  <= collision_d;
            inv_err_q    <= inv_err_d;
        end
    end

    assign sbox_data_o  = sbox_data_q;
    assign sbox_valid_o = sbox_valid_q;
    assign dp_grant_o   = dp_grant_s;
    assign dp_data_o    = dp_data_q;
    assign dp_valid_o   = dp_valid_q;
    assign collision_o  = collision_q;
    assign inv_err_o    = inv_err_q;

endmodule

// File: doc/aes_sbox_server.md
# aes_sbox_server

Shared AES S-box responder serving byte lookups for the key scheduler and the round datapath. It sits between those two requesters and a single arithmetic S-box core. It answers forward (encrypt) or inverse (decrypt) substitutions with a fixed one-cycle latency. It arbitrates simultaneous requests with fixed priority, and the key-scheduler port is never stalled.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- sbox_access_i  in  1  key-scheduler request strobe
- sbox_data_i  in  8  key-scheduler byte to substitute
- sbox_decrypt_i  in  1  key-scheduler direction: 1 = inverse S-box
- sbox_data_o  out  8  key-scheduler result, valid the cycle after sbox_access_i
- sbox_valid_o  out  1  key-scheduler result valid
- dp_access_i  in  1  datapath request strobe
- dp_data_i  in  8  datapath byte
- dp_decrypt_i  in  1  datapath direction
- dp_grant_o  out  1  combinational: dp_access_i & ~sbox_access_i
- dp_data_o  out  8  datapath result
- dp_valid_o  out  1  datapath result valid (registered dp_grant_o)
- clear_i  in  1  clears the sticky flags
- collision_o  out  1  sticky: both ports requested in the same cycle
- inv_err_o  out  1  sticky: inverse requested while inverse support is compiled out

## Operation
- One shared S-box core. Each cycle the mux selects the key-scheduler byte and direction if sbox_access_i is high, otherwise the datapath byte and direction.
- Core output is registered into the result register of the winning port. The other result register holds its last value.
- Key-scheduler port has absolute priority. A requester that ignores grant relies on this and must never lose a cycle.
- Datapath denied (dp_access_i & sbox_access_i):
  - dp_grant_o = 0.
  - No datapath result next cycle.
  - Datapath must hold its request and retry.
  - collision_o sets.
- Forward lookup = GF(2^8) multiplicative inverse (0 maps to 0) followed by the affine transform with constant 0x63.
- Inverse lookup = inverse affine transform (constant 0x05) followed by the GF inverse.
- Polynomial: x^8+x^4+x^3+x+1.
- Sticky flags:
  - Set on their event and held until clear_i.
  - Set and clear in the same cycle: set wins.
- No internal state machine beyond the result and valid registers and the sticky flags. Back-to-back requests on every cycle are fully supported.

## Timing
- Latency: exactly 1 cycle, request at edge N, result and valid visible after edge N+1. Throughput: 1 lookup per cycle total across both ports.
- sbox_valid_o and dp_valid_o are single-cycle pulses per accepted request. Consecutive requests give continuous valid.
- Reset values: sbox_data_o = 0x00, dp_data_o = 0x00, sbox_valid_o = 0, dp_valid_o = 0, collision_o = 0, inv_err_o = 0.
- dp_grant_o is combinational and therefore not reset. With both access inputs low it is 0.
- Reset asserted mid-request: the result and valid registers go to reset values at that edge. The request in flight is dropped with no valid pulse.
- A request presented in the cycle reset deasserts is accepted normally.
- Direction is sampled with the data. Mixed forward and inverse requests on consecutive cycles are legal.

## Configuration
- AES_SBOX_INV_EN defined:
  - Inverse path compiled in.
  - decrypt inputs select the inverse S-box.
  - inv_err_o is tied 0.
- AES_SBOX_INV_EN undefined:
  - Inverse affine logic and its mux are removed.
  - All lookups are forward regardless of decrypt inputs.
  - Any accepted request with its decrypt input high sets inv_err_o.

## Structure
- Shared package aes_pkg holds:
  - AES_AFFINE_C = 8'h63
  - AES_INV_AFFINE_C = 8'h05
  - AES_POLY = 9'h11B
  - the byte typedef aes_byte_t
- Sub-module aes_sbox_core: purely combinational, with ports data_i[7:0], inv_i and data_o[7:0]. It contains the GF inverse (composite-field or exponentiation form, no 256-entry table) and both affine transforms. The inverse affine is under AES_SBOX_INV_EN.
- Top module: arbitration mux, result/valid registers, sticky flags.

## Test plan
- Forward singles on the key-scheduler port:
  - 0x00 -> 0x63
  - 0x01 -> 0x7C
  - 0x53 -> 0xED
  - sbox_valid_o pulses one cycle after each request.
- Key-scheduler burst on 4 consecutive cycles: 0x09, 0xCF, 0x4F, 0x3C -> results 0x01, 0x8A, 0x84, 0xEB on 4 consecutive cycles with continuous valid.
- Inverse on the datapath port (macro defined):
  - 0x63 -> 0x00
  - 0xED -> 0x53
  - 0x7C -> 0x01
  - dp_grant_o = 1 and dp_valid_o follows.
- Collision, same cycle:
  - Stimulus: key scheduler 0x53 and datapath 0x00.
  - Response: sbox_data_o = 0xED, dp_grant_o = 0, no dp_valid_o, collision_o = 1.
  - Datapath retries next cycle -> dp_data_o = 0x63.
  - clear_i -> collision_o = 0.
- Reset:
  - Assert reset on the cycle after a request -> no valid pulse, all outputs at reset values.
  - Request on the first cycle after release -> correct result.
- Macro undefined: decrypt request with 0x63 -> result 0x FB (forward S(0x63)), inv_err_o = 1 until clear_i.
